// File: rtl/mpmc11_rd_fifo_sel.sv
// Read-FIFO channel selector: round-robin offer of a readable FIFO to the memory
// controller, with ack/done handshake, offer timeout and optional channel-0 priority.
module mpmc11_rd_fifo_sel #(
  parameter int NCH       = 9,
  parameter bit HIPRI_CH0 = 1'b0,
  parameter int TMO       = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] rd,
  input  logic       ack,
  input  logic       done,
  output logic       sel_valid,
  output logic [3:0] sel_ch,
  output logic [8:0] sel_oh,
  output logic [8:0] fifo_rd,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OFFER, ACTIVE} state_t;

  localparam logic [7:0] TMO_W = 8'(TMO);
  localparam logic [4:0] NCH_W = 5'(NCH);

  state_t     state;
  logic [3:0] last;
  logic [7:0] wcnt;

  logic [8:0] rd_m;
  logic [4:0] start;
  logic [4:0] idx;
  logic       win_found;
  logic [3:0] win_ch;
  logic [8:0] win_oh;

  // Winner search: rotate from last+1, wrapping at the top channel.
  always_comb begin
    rd_m      = '0;
    start     = '0;
    idx       = '0;
    win_found = 1'b0;
    win_ch    = '0;
    win_oh    = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < NCH) rd_m[i] = rd[i];
    end
    if (({1'b0, last} + 5'd1) >= NCH_W) start = 5'd0;
    else                                start = {1'b0, last} + 5'd1;
    for (int k = 0; k < 9; k++) begin
      idx = start + 5'(k);
      if (idx >= NCH_W) idx = idx - NCH_W;
      if (k < NCH && !win_found && rd_m[idx[3:0]]) begin
        win_found = 1'b1;
        win_ch    = idx[3:0];
      end
    end
    if (HIPRI_CH0 && rd_m[0]) begin
      win_found = 1'b1;
      win_ch    = 4'd0;
    end
    win_oh = 9'd1 << win_ch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 4'd8;
      wcnt      <= '0;
      sel_valid <= 1'b0;
      sel_ch    <= '0;
      sel_oh    <= '0;
      fifo_rd   <= '0;
      busy      <= 1'b0;
    end else begin
      fifo_rd <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            sel_ch    <= win_ch;
            sel_oh    <= win_oh;
            sel_valid <= 1'b1;
            wcnt      <= '0;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (ack) begin
            fifo_rd   <= sel_oh;
            sel_valid <= 1'b0;
            busy      <= 1'b1;
            last      <= sel_ch;
            state     <= ACTIVE;
          end else if (!rd_m[sel_ch]) begin
            sel_valid <= 1'b0;
            state     <= IDLE;
          end else if ((wcnt + 8'd1) >= TMO_W) begin
            // Stalled channel becomes "last" so the next search skips past it.
            sel_valid <= 1'b0;
            last      <= sel_ch;
            state     <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ACTIVE: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc11_rd_fifo_sel.sv
// Bench for mpmc11_rd_fifo_sel: three configurations share stimulus and are checked
// every cycle against a transaction-level reference, plus vector table and directed cases.
module tb_mpmc11_rd_fifo_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] rd = '0;
  logic       ack = 1'b0;
  logic       done = 1'b0;

  logic [2:0] sv;
  logic [2:0] bz;
  logic [3:0] sc [3];
  logic [8:0] so [3];
  logic [8:0] fr [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpmc11_rd_fifo_sel #(.NCH(9), .HIPRI_CH0(1'b0), .TMO(15)) u0 (
    .clk(clk), .rst(rst), .rd(rd), .ack(ack), .done(done),
    .sel_valid(sv[0]), .sel_ch(sc[0]), .sel_oh(so[0]), .fifo_rd(fr[0]), .busy(bz[0]));
  mpmc11_rd_fifo_sel #(.NCH(9), .HIPRI_CH0(1'b1), .TMO(15)) u1 (
    .clk(clk), .rst(rst), .rd(rd), .ack(ack), .done(done),
    .sel_valid(sv[1]), .sel_ch(sc[1]), .sel_oh(so[1]), .fifo_rd(fr[1]), .busy(bz[1]));
  mpmc11_rd_fifo_sel #(.NCH(9), .HIPRI_CH0(1'b0), .TMO(4)) u2 (
    .clk(clk), .rst(rst), .rd(rd), .ack(ack), .done(done),
    .sel_valid(sv[2]), .sel_ch(sc[2]), .sel_oh(so[2]), .fifo_rd(fr[2]), .busy(bz[2]));

  // Reference: 0 = waiting for candidates, 1 = offering, 2 = transaction running.
  bit   cfg_hp [3]  = '{1'b0, 1'b1, 1'b0};
  int   cfg_tmo [3] = '{15, 15, 4};
  int   m_st [3];
  int   m_last [3];
  int   m_wait [3];
  int   m_ch [3];
  bit   m_valid [3];
  bit   m_busy [3];
  logic [8:0] m_fifo [3];

  function automatic int pick(logic [8:0] r, int lst, bit hp);
    int i;
    if (hp && r[0]) return 0;
    for (int k = 1; k <= 9; k++) begin
      i = (lst + k) % 9;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pk(logic v, logic b, logic [8:0] f, logic [3:0] c, logic [8:0] o);
    if (v) return {8'd0, v, b, f, c, o};
    return {8'd0, v, b, f, 13'd0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_st[c] = 0; m_last[c] = 8; m_wait[c] = 0; m_ch[c] = 0;
      m_valid[c] = 1'b0; m_busy[c] = 1'b0; m_fifo[c] = '0;
    end
  endtask

  task automatic model_step();
    int w;
    for (int c = 0; c < 3; c++) begin
      m_fifo[c] = '0;
      case (m_st[c])
        0: begin
          w = pick(rd, m_last[c], cfg_hp[c]);
          if (w >= 0) begin
            m_ch[c] = w; m_valid[c] = 1'b1; m_wait[c] = 0; m_st[c] = 1;
          end
        end
        1: begin
          if (ack) begin
            m_fifo[c] = 9'd1 << m_ch[c]; m_valid[c] = 1'b0; m_busy[c] = 1'b1;
            m_last[c] = m_ch[c]; m_st[c] = 2;
          end else if (!rd[m_ch[c]]) begin
            m_valid[c] = 1'b0; m_st[c] = 0;
          end else if (m_wait[c] + 1 >= cfg_tmo[c]) begin
            m_valid[c] = 1'b0; m_last[c] = m_ch[c]; m_st[c] = 0;
          end else begin
            m_wait[c]++;
          end
        end
        default: begin
          if (done) begin
            m_busy[c] = 1'b0; m_st[c] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    for (int d = 0; d < 3; d++)
      check($sformatf("model_u%0d", d),
            pk(sv[d], bz[d], fr[d], sc[d], so[d]),
            pk(m_valid[d], m_busy[d], m_fifo[d], 4'(m_ch[d]), 9'd1 << m_ch[d]));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_u%0d", d), {7'd0, sv[d], bz[d], sc[d], so[d], fr[d]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [8:0] rd;
    logic       ack;
    logic       done;
    logic       valid;
    logic [3:0] ch;
    logic [8:0] fifo;
    logic       busy;
  } vec_t;

  vec_t vt [13];
  int   n;

  initial begin
    vt[0]  = '{9'h004, 1'b0, 1'b0, 1'b1, 4'd2, 9'h000, 1'b0};
    vt[1]  = '{9'h004, 1'b1, 1'b0, 1'b0, 4'd0, 9'h004, 1'b1};
    vt[2]  = '{9'h014, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b1};
    vt[3]  = '{9'h014, 1'b0, 1'b1, 1'b0, 4'd0, 9'h000, 1'b0};
    vt[4]  = '{9'h014, 1'b0, 1'b0, 1'b1, 4'd4, 9'h000, 1'b0};
    vt[5]  = '{9'h014, 1'b1, 1'b0, 1'b0, 4'd0, 9'h010, 1'b1};
    vt[6]  = '{9'h014, 1'b0, 1'b1, 1'b0, 4'd0, 9'h000, 1'b0};
    vt[7]  = '{9'h014, 1'b0, 1'b0, 1'b1, 4'd2, 9'h000, 1'b0};
    vt[8]  = '{9'h010, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b0};
    vt[9]  = '{9'h010, 1'b0, 1'b0, 1'b1, 4'd4, 9'h000, 1'b0};
    vt[10] = '{9'h000, 1'b1, 1'b0, 1'b0, 4'd0, 9'h010, 1'b1};
    vt[11] = '{9'h000, 1'b1, 1'b1, 1'b0, 4'd0, 9'h000, 1'b0};
    vt[12] = '{9'h000, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b0};

    model_reset();
    #1;
    do_reset();

    // Vector table on the default configuration.
    for (int i = 0; i < 13; i++) begin
      rd = vt[i].rd; ack = vt[i].ack; done = vt[i].done;
      tick();
      check($sformatf("table_%0d", i), pk(sv[0], bz[0], fr[0], sc[0], so[0]),
            pk(vt[i].valid, vt[i].busy, vt[i].fifo, vt[i].ch, 9'd1 << vt[i].ch));
    end
    ack = 1'b0; done = 1'b0;

    // Full request vector: strict rotation 0..8,0.
    do_reset();
    rd = 9'h1FF;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!sv[0] && n < 20) begin tick(); n++; end
      check($sformatf("rr_grant_%0d", g), {27'd0, sv[0], sc[0]}, {27'd0, 1'b1, 4'(g % 9)});
      ack = 1'b1; tick();
      check($sformatf("rr_pop_%0d", g), {23'd0, fr[0]}, {23'd0, 9'd1 << (g % 9)});
      ack = 1'b0; tick(); tick();
      done = 1'b1; tick(); done = 1'b0;
    end

    // Channel-0 priority configuration.
    do_reset();
    rd = 9'h181;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!sv[1] && n < 20) begin tick(); n++; end
      check($sformatf("hipri_%0d", g), {27'd0, sv[1], sc[1]}, {27'd0, 1'b1, 4'd0});
      ack = 1'b1; tick(); ack = 1'b0;
      done = 1'b1; tick(); done = 1'b0;
    end

    // Withdraw on candidate loss, then ack winning over a same-cycle drop.
    do_reset();
    rd = 9'h008; tick();
    check("wd_offer", {27'd0, sv[0], sc[0]}, {27'd0, 1'b1, 4'd3});
    rd = 9'h000; tick();
    check("wd_drop", {22'd0, sv[0], fr[0]}, 32'd0);
    rd = 9'h1FF; tick();
    check("wd_last_kept", {27'd0, sv[0], sc[0]}, {27'd0, 1'b1, 4'd0});
    rd = 9'h008; tick(); tick();
    check("wd_reoffer", {27'd0, sv[0], sc[0]}, {27'd0, 1'b1, 4'd3});
    ack = 1'b1; rd = 9'h000; tick();
    check("ack_vs_drop", {23'd0, fr[0]}, 32'h008);
    ack = 1'b0; done = 1'b1; tick(); done = 1'b0;

    // Timeout on the TMO=4 instance.
    do_reset();
    rd = 9'h020; tick();
    check("tmo_offer", {27'd0, sv[2], sc[2]}, {27'd0, 1'b1, 4'd5});
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("tmo_hold_%0d", k), {31'd0, sv[2]}, 32'd1);
    end
    tick();
    check("tmo_withdraw", {31'd0, sv[2]}, 32'd0);
    rd = 9'h060; tick();
    check("tmo_skip", {27'd0, sv[2], sc[2]}, {27'd0, 1'b1, 4'd6});

    // Reset in the middle of a running transaction.
    do_reset();
    rd = 9'h1FF; tick();
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("mid_active_busy", {31'd0, bz[0]}, 32'd1);
    do_reset();
    tick();
    check("post_reset_grant", {27'd0, sv[0], sc[0]}, {27'd0, 1'b1, 4'd0});

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = 9'($urandom);
        1:       rd = 9'd1 << $urandom_range(0, 8);
        2:       rd = rd;
        default: rd = rd | 9'($urandom) & 9'($urandom);
      endcase
      ack  = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpmc11_rd_fifo_sel.md
MPMC11_RD_FIFO_SEL -- requirements
Module: mpmc11_rd_fifo_sel

Interface
REQ-001 SHALL have parameter NCH, default 9: number of read FIFO channels.
REQ-002 SHALL have parameter HIPRI_CH0, default 0: when 1, channel 0 wins whenever it is a candidate.
REQ-003 SHALL have parameter TMO, default 15: OFFER-state cycles without ack before the offer is withdrawn; range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rd, input, 9 bits: registered candidate vector from the read-FIFO generator; bit n=1 means FIFO n is readable.
REQ-007 SHALL have port ack, input, 1 bit: controller accepts the offered channel.
REQ-008 SHALL have port done, input, 1 bit: controller finished the accepted transaction.
REQ-009 SHALL have port sel_valid, output, 1 bit: an offer is presented.
REQ-010 SHALL have port sel_ch, output, 4 bits: encoded offered channel (0..8).
REQ-011 SHALL have port sel_oh, output, 9 bits: one-hot offered channel.
REQ-012 SHALL have port fifo_rd, output, 9 bits: one-cycle pop pulse to the accepted FIFO.
REQ-013 SHALL have port busy, output, 1 bit: a transaction is accepted and not yet done.

Function
REQ-014 SHALL implement states IDLE, OFFER and ACTIVE; reset state SHALL be IDLE.
REQ-015 SHALL hold a round-robin pointer "last" (4 bits); search SHALL start at last+1 and wrap from 8 to 0.
REQ-016 In IDLE with rd!=0, the block SHALL register the winner into sel_ch/sel_oh, assert sel_valid and enter OFFER; latency is 1 cycle from rd to sel_valid.
REQ-017 When HIPRI_CH0=1 and rd[0]=1 in IDLE, channel 0 SHALL win regardless of last.
REQ-018 In IDLE with rd==0, the block SHALL remain in IDLE with sel_valid=0.
REQ-019 In OFFER, sel_ch and sel_oh SHALL stay stable until exit, and sel_oh SHALL be exactly one-hot of sel_ch.
REQ-020 In OFFER with ack=1, the next cycle SHALL have fifo_rd=sel_oh for exactly 1 cycle, sel_valid=0, busy=1, last=sel_ch, and state ACTIVE.
REQ-021 In OFFER with ack=0 and rd[sel_ch]=0, the block SHALL withdraw: sel_valid=0 next cycle, state IDLE, last unchanged.
REQ-022 If ack=1 and rd[sel_ch] drops in the same cycle, ack SHALL take priority over withdraw.
REQ-023 An 8-bit wait counter SHALL clear on OFFER entry and increment each OFFER cycle without ack.
REQ-024 When the wait counter reaches TMO without ack, the block SHALL withdraw to IDLE and set last=sel_ch so the stalled channel is skipped next search.
REQ-025 ACTIVE SHALL hold busy=1 and sel_valid=0 until done=1; the next cycle SHALL be IDLE with busy=0.
REQ-026 done in IDLE or OFFER, and ack outside OFFER, SHALL be ignored.
REQ-027 The earliest new sel_valid after done SHALL be 2 cycles after the done cycle.
REQ-028 rd bits at index >= NCH SHALL be ignored.
REQ-029 fifo_rd SHALL have at most one bit set in any cycle and SHALL never be set outside the cycle after an accepted ack.

Reset
REQ-030 While rst=0, the block SHALL immediately force state=IDLE, last=8, wait counter=0, and sel_valid=0, sel_ch=0, sel_oh=0, fifo_rd=0, busy=0.
REQ-031 Reset asserted mid-OFFER or mid-ACTIVE SHALL abandon the transaction without emitting a fifo_rd pulse.
REQ-032 After rst deasserts, the first search SHALL start at channel 0.

Verification
REQ-033 Reset, then rd=9'h1FF held, ack 1 cycle after each sel_valid and done 3 cycles after ack -> grants 0,1,...,8,0 in order, each with a single fifo_rd pulse.
REQ-034 rd=9'h014, last=2 -> sel_ch=4, sel_oh=9'h010; after ack and done, with rd unchanged -> sel_ch=2.
REQ-035 HIPRI_CH0=1, rd=9'h181, last=0 -> sel_ch=0 on every grant.
REQ-036 Offer ch3, rd[3] cleared before ack -> sel_valid=0 next cycle, no fifo_rd, last unchanged; ack and rd[3] drop in the same cycle -> fifo_rd=9'h008.
REQ-037 TMO=4, offer ch5, ack never asserted -> withdraw after 4 OFFER cycles; with rd=9'h060 -> next sel_ch=6.
REQ-038 rst pulsed low in ACTIVE -> all outputs 0 asynchronously, no fifo_rd, and with rd=9'h1FF the next grant is ch0.
